// File: rtl/fetch_sequencer.sv
// LEGv8 fetch-stage controller: owns the PC, issues imem requests over req/ack and
// hands fetched instructions to decode over valid/ready, applying taken-branch redirects.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             resetl,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [63:0]      inst_pc,
  input  logic             inst_ready,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [63:0]      br_pc,
  input  logic [63:0]      br_imm,
  input  logic             halt,
  output logic [63:0]      pc,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [2:0]       fsm_state
);

  // Handshakes: an imem transfer happens on a rising edge where imem_req && imem_ack;
  // decode acceptance happens on a rising edge where inst_valid && inst_ready.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t      state;
  logic [63:0] drain_addr;
  logic [63:0] target;
  logic        redirect;
  logic        xfer;
  logic        accept;

  assign redirect  = br_valid && br_taken;
  assign xfer      = imem_req && imem_ack;
  assign accept    = inst_valid && inst_ready;
  assign target    = br_pc + (br_imm << 2);
  // A request that cannot be aborted keeps presenting its original address.
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign fsm_state = state;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      taken_cnt  <= '0;
    end else begin
      if (redirect) begin
        pc         <= target;
        inst_valid <= 1'b0;
        if (taken_cnt != {CNT_W{1'b1}})
          taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (redirect) begin
            state <= REQ;
          end else if (xfer) begin
            inst       <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            // Ack landing with the redirect already retires the stale request.
            if (xfer) begin
              state <= REQ;
            end else begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (xfer) begin
            inst       <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            imem_req <= 1'b1;
            state    <= REQ;
          end else if (accept) begin
            inst_valid <= 1'b0;
            pc         <= pc + 64'd4;
            if (halt) begin
              state <= HALTED;
            end else begin
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        HALTED: begin
          if (redirect) begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end
        DRAIN: begin
          if (xfer)
            state <= REQ;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory model answers requests and a queue of
// expected {inst_pc, inst} pairs is checked at every decode acceptance.
module tb_fetch_sequencer;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam logic [63:0] S_IDLE = 64'd0, S_REQ = 64'd1, S_WAIT = 64'd2,
                          S_HOLD = 64'd3, S_DRAIN = 64'd4, S_HALTED = 64'd5;
  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        CLK;
  logic        resetl;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        br_valid;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [63:0] br_imm;
  logic        halt;
  logic [63:0] pc;
  logic [15:0] taken_cnt;
  logic [2:0]  fsm_state;

  logic        s_req, s_valid;
  logic [63:0] s_addr, s_inst_pc, s_pc;
  logic [31:0] s_inst;
  logic [1:0]  s_cnt;
  logic [2:0]  s_state;

  logic [95:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_redir = 0;

  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'h8B00_0000 ^ a[31:0];
  endfunction

  assign imem_data = word(imem_addr);

  fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .CLK(CLK), .resetl(resetl), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .br_valid(br_valid), .br_taken(br_taken),
    .br_pc(br_pc), .br_imm(br_imm), .halt(halt), .pc(pc), .taken_cnt(taken_cnt),
    .fsm_state(fsm_state)
  );

  fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(2)) u_sat (
    .CLK(CLK), .resetl(resetl), .imem_req(s_req), .imem_addr(s_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(s_valid), .inst(s_inst),
    .inst_pc(s_inst_pc), .inst_ready(inst_ready), .br_valid(br_valid), .br_taken(br_taken),
    .br_pc(br_pc), .br_imm(br_imm), .halt(halt), .pc(s_pc), .taken_cnt(s_cnt),
    .fsm_state(s_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [63:0] a);
    exp_q.push_back({a, word(a)});
  endtask

  task automatic br_tick(input logic [63:0] p, input logic [63:0] imm, input logic tk);
    br_valid = 1'b1;
    br_taken = tk;
    br_pc    = p;
    br_imm   = imm;
    if (tk) n_redir++;
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
  endtask

  // scoreboard: every acceptance consumes the oldest expected instruction
  always @(negedge CLK) begin
    logic [95:0] e;
    if (resetl && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("accept_unexpected", inst_pc, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("accept_pc", inst_pc, e[95:32]);
        chk("accept_inst", {32'd0, inst}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    logic [63:0] a;
    resetl = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0; halt = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_imm = '0;
    repeat (2) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_cnt", taken_cnt, 0);
    chk("rst_state", fsm_state, S_IDLE);

    // boot with ack and ready tied high
    imem_ack = 1'b1; inst_ready = 1'b1; resetl = 1'b1;
    chk("boot_req0", imem_req, 0);
    for (int k = 0; k < 3; k++) begin
      a = RST_PC + 64'(4 * k);
      tick();
      chk("boot_req", imem_req, 1);
      chk("boot_addr", imem_addr, a);
      push(a);
      tick();
      chk("boot_valid", inst_valid, 1);
      chk("boot_inst_pc", inst_pc, a);
      chk("boot_req_hold", imem_req, 0);
      if (k == 2) imem_ack = 1'b0;
    end
    tick();
    chk("req_10c_state", fsm_state, S_REQ);
    chk("req_10c_addr", imem_addr, 64'h10C);
    inst_ready = 1'b0;

    // redirect in REQ, then wait states at 0x200
    br_tick(64'h200, 64'h0, 1'b1);
    chk("rq_redir_pc", pc, 64'h200);
    chk("rq_redir_cnt", taken_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 64'h200);
      if (i == 3) begin imem_ack = 1'b1; push(64'h200); end
      tick();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", {32'd0, inst}, {32'd0, word(64'h200)});
      chk("hold_inst_pc", inst_pc, 64'h200);
      chk("hold_noreq", imem_req, 0);
      tick();
    end
    chk("hold_state", fsm_state, S_HOLD);

    // not-taken branch is ignored
    br_tick(64'h1234, 64'h5, 1'b0);
    chk("nt_state", fsm_state, S_HOLD);
    chk("nt_pc", pc, 64'h200);
    chk("nt_valid", inst_valid, 1);
    chk("nt_cnt", taken_cnt, 1);

    // redirect together with acceptance: redirect wins
    inst_ready = 1'b1;
    br_tick(64'h300, 64'h0, 1'b1);
    inst_ready = 1'b0;
    chk("ra_pc", pc, 64'h300);
    chk("ra_state", fsm_state, S_REQ);
    chk("ra_valid", inst_valid, 0);
    chk("ra_cnt", taken_cnt, 2);
    imem_ack = 1'b1; push(64'h300);
    tick();
    imem_ack = 1'b0;
    chk("h300_inst_pc", inst_pc, 64'h300);

    // redirect in HOLD with negative offset; the held instruction is flushed
    void'(exp_q.pop_front());
    br_tick(64'h2F0, NEG2, 1'b1);
    chk("rh_pc", pc, 64'h2E8);
    chk("rh_valid", inst_valid, 0);
    chk("rh_addr", imem_addr, 64'h2E8);
    chk("rh_req", imem_req, 1);
    chk("rh_cnt", taken_cnt, 3);
    br_tick(64'h300, NEG2, 1'b0);
    chk("rh_nt_state", fsm_state, S_WAIT);
    chk("rh_nt_pc", pc, 64'h2E8);
    chk("rh_nt_cnt", taken_cnt, 3);

    // redirect during WAIT drains the old request
    br_tick(64'h400, 64'h0, 1'b1);
    chk("d1_state", fsm_state, S_DRAIN);
    chk("d1_pc", pc, 64'h400);
    chk("d1_addr", imem_addr, 64'h2E8);
    chk("d1_cnt", taken_cnt, 4);
    tick();
    chk("d1_addr_hold", imem_addr, 64'h2E8);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("d1_done_state", fsm_state, S_REQ);
    chk("d1_done_addr", imem_addr, 64'h400);
    chk("d1_done_valid", inst_valid, 0);
    tick();
    chk("w400_state", fsm_state, S_WAIT);
    br_tick(64'h400, 64'h10, 1'b1);
    chk("d2_pc", pc, 64'h440);
    chk("d2_cnt", taken_cnt, 5);
    for (int i = 0; i < 2; i++) begin
      chk("d2_addr", imem_addr, 64'h400);
      chk("d2_valid", inst_valid, 0);
      tick();
    end
    imem_ack = 1'b1;
    tick();
    chk("d2_done_valid", inst_valid, 0);
    chk("d2_done_addr", imem_addr, 64'h440);
    push(64'h440);
    tick();
    chk("h440_inst_pc", inst_pc, 64'h440);
    inst_ready = 1'b1;
    tick();
    chk("r444_addr", imem_addr, 64'h444);

    // redirect in REQ with a simultaneous ack drops the returned word
    br_tick(64'h500, 64'h0, 1'b1);
    chk("rqa_state", fsm_state, S_REQ);
    chk("rqa_pc", pc, 64'h500);
    chk("rqa_valid", inst_valid, 0);
    halt = 1'b1; push(64'h500);
    tick();
    chk("h500_inst_pc", inst_pc, 64'h500);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("halt_state", fsm_state, S_HALTED);
      chk("halt_pc", pc, 64'h504);
      chk("halt_req", imem_req, 0);
      tick();
    end
    br_tick(64'h500, 64'h1, 1'b1);
    chk("resume_state", fsm_state, S_REQ);
    chk("resume_addr", imem_addr, 64'h504);
    chk("resume_cnt", taken_cnt, 7);
    push(64'h504);
    tick();
    // redirect + halt + acceptance together, with address wrap
    halt = 1'b1;
    br_tick(64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 1'b1);
    halt = 1'b0;
    chk("wrap_state", fsm_state, S_REQ);
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_cnt", taken_cnt, 8);
    chk("sat_cnt", s_cnt, (n_redir > 3) ? 64'd3 : 64'(n_redir));

    // asynchronous reset between edges while a request is outstanding
    imem_ack = 1'b0;
    tick();
    chk("pre_rst_state", fsm_state, S_WAIT);
    #3 resetl = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_pc", pc, RST_PC);
    chk("arst_state", fsm_state, S_IDLE);
    chk("arst_valid", inst_valid, 0);
    chk("arst_cnt", taken_cnt, 0);
    chk("arst_sat_cnt", s_cnt, 0);
    imem_ack = 1'b1;
    tick();
    chk("late_ack_state", fsm_state, S_IDLE);
    chk("late_ack_valid", inst_valid, 0);
    resetl = 1'b1;
    tick();
    chk("restart_state", fsm_state, S_REQ);
    chk("restart_addr", imem_addr, RST_PC);
    chk("restart_valid", inst_valid, 0);
    push(RST_PC);
    inst_ready = 1'b1;
    tick();
    chk("restart_inst_pc", inst_pc, RST_PC);
    imem_ack = 1'b0;
    tick();
    chk("restart_next_addr", imem_addr, RST_PC + 64'd4);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller for the LEGv8 datapath. It owns the architectural PC register and sequences instruction-memory requests over a req/ack handshake. It presents fetched instructions to decode over a valid/ready handshake. It applies PC+4 or taken-branch redirects (target = branch PC + (imm << 2)) from execute, including flushing an in-flight fetch.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
CNT_W, 16, width of the taken-redirect counter.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
resetl  input  1  reset, asynchronous assert, active-low.
imem_req  output  1  instruction fetch request.
imem_addr  output  64  fetch address; equals pc while imem_req=1.
imem_ack  input  1  memory returns imem_data this cycle; transfer = imem_req && imem_ack.
imem_data  input  32  instruction word; valid only on a transfer.
inst_valid  output  1  inst/inst_pc hold a valid instruction for decode.
inst  output  32  fetched instruction.
inst_pc  output  64  PC of inst.
inst_ready  input  1  decode accepts; acceptance = inst_valid && inst_ready.
br_valid  input  1  execute reports a resolved branch this cycle.
br_taken  input  1  resolved outcome (Uncondbranch || (Branch && ALUZero)), qualified by br_valid.
br_pc  input  64  PC of the resolving branch.
br_imm  input  64  sign-extended branch offset, in words.
halt  input  1  stop fetching after the current acceptance.
pc  output  64  current PC register.
taken_cnt  output  CNT_W  count of applied redirects.

Behaviour:
- Reset (resetl=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, taken_cnt=0.
  - Reset asserted mid-fetch abandons the fetch; a late imem_ack is ignored.
- States: IDLE, REQ, WAIT, HOLD, DRAIN, HALTED.
- IDLE: first edge with resetl=1 -> REQ.
- REQ/WAIT:
  - imem_req=1, imem_addr=pc; the address is held stable until the transfer.
  - On transfer: inst<=imem_data, inst_pc<=pc, inst_valid<=1 -> HOLD.
  - No ack in REQ -> WAIT; no ack in WAIT -> stay in WAIT.
- HOLD:
  - imem_req=0; inst/inst_pc/inst_valid are stable until acceptance.
  - On acceptance: inst_valid<=0, pc<=pc+4, then -> HALTED if halt=1, else -> REQ.
- HALTED: imem_req=0, pc held. Only a redirect exits (-> REQ).
- Redirect = br_valid && br_taken:
  - target = br_pc + (br_imm << 2), computed modulo 2^64; bits shifted out above bit 63 are discarded.
  - pc<=target, inst_valid<=0, taken_cnt<=taken_cnt+1, saturating at all-ones.
  - From IDLE/REQ/HOLD/HALTED -> REQ.
  - In REQ with imem_ack=1 the same cycle: the returned data is discarded, not latched.
  - From WAIT -> DRAIN. A request cannot be aborted; the redirect applies to pc immediately.
- DRAIN:
  - imem_req=1, imem_addr = the old address (held in an internal register), not the new pc.
  - On transfer: discard data -> REQ.
  - A further redirect in DRAIN updates pc and taken_cnt; state stays DRAIN.
- br_valid && !br_taken: no effect on any state or output.
- Simultaneous events:
  - Redirect and acceptance in the same HOLD cycle: redirect wins. pc=target, not pc+4; the accepted instruction is still considered consumed.
  - Redirect and halt in the same cycle: redirect wins; next state is REQ.
  - halt is sampled only at an acceptance.
- Throughput: minimum 2 cycles per instruction (REQ with immediate ack, then HOLD with ready).

Test Plan:
- Reset/boot, RESET_PC=64'h100, imem_ack tied 1, inst_ready tied 1 -> imem_addr sequence 0x100, 0x104, 0x108 on every other cycle. The first imem_req appears one cycle after resetl rises. inst_pc matches each address.
- Wait states: ack delayed 3 cycles at pc=0x200 -> imem_addr held at 0x200 for 4 cycles, then inst_valid=1 with inst = the returned word. inst_ready held 0 for 5 cycles -> inst/inst_pc stable throughout, no new request.
- Redirect in HOLD: pc=0x300 in HOLD, br_valid=1, br_taken=1, br_pc=0x2F0, br_imm=-2 (all ones) -> pc=0x2E8, inst_valid=0 next cycle, next imem_addr=0x2E8, taken_cnt=1. Repeat with br_taken=0 -> no change.
- Redirect during WAIT: request at 0x400 outstanding, redirect with br_pc=0x400, br_imm=0x10 -> pc=0x440. Request stays at 0x400 until ack, the data is dropped (inst_valid stays 0), then a request at 0x440.
- Halt and resume: halt=1 at acceptance of inst_pc=0x500 -> pc=0x504, imem_req=0 indefinitely. Then redirect with br_pc=0x500, br_imm=1 -> request at 0x504. Also a wrap case: br_pc=64'hFFFF_FFFF_FFFF_FFFC, br_imm=1 -> pc=0.
- Async reset mid-WAIT, plus counter saturation: resetl pulsed low between edges -> outputs clear immediately, the late ack is ignored, and fetch restarts at RESET_PC. Separately, with CNT_W=2, 5 redirects -> taken_cnt=3.
